boot_loader: RTL and testbench

//   Program loader sitting directly upstream of the 8-bit pipelined CPU top.
//   - Accepts a byte stream (valid/ready) and assembles 24-bit instruction words.
//   - Writes the words into the FE-stage instruction memory.
//   - Verifies an XOR checksum over the stream.
//   - Holds the CPU's master_reset asserted until a good image is loaded, then releases it.

---
 rtl/boot_loader.sv | 99 +++++++++
 tb/tb_boot_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader; assembles 24-bit words into imem, checks XOR checksum, gates cpu_reset.
module boot_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);
  typedef enum logic [2:0] {IDLE, LEN, BYTE, WRITE, CSUM, HOLD, RUN, ERR} state_t;
  localparam int CNT_W = $clog2(DEPTH);
  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d, csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       word_q, word_d;
  logic [3:0]        hold_q, hold_d;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, RUN, ERR: state_d = load_start ? LEN : state_q;
      LEN: if (byte_valid) begin
        n_d     = byte_in;
        csum_d  = byte_in;
        cnt_d   = '0;
        idx_d   = '0;
        addr_d  = '0;
        state_d = (byte_in == 8'd0) ? CSUM : BYTE;
      end
      BYTE: if (byte_valid) begin
        word_d  = {word_q[15:0], byte_in};
        csum_d  = csum_q ^ byte_in;
        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        state_d = (idx_q == 2'd2) ? WRITE : BYTE;
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (8'(cnt_q + 1'b1) == n_q) ? CSUM : BYTE;
      end
      CSUM: if (byte_valid) begin
        hold_d  = '0;
        state_d = (byte_in == csum_q) ? HOLD : ERR;
      end
      HOLD: begin
        hold_d  = hold_q + 4'd1;
        state_d = (hold_q == 4'(RESET_HOLD - 1)) ? RUN : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
    end
  end
  // All outputs decode registered state only, so no input reaches an output combinationally.
  assign byte_ready = state_q inside {LEN, BYTE, CSUM};
  assign imem_we    = state_q == WRITE;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign cpu_reset  = state_q != RUN;
  assign load_done  = state_q == RUN;
  assign load_error = state_q == ERR;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized scoreboard bench for boot_loader against a stream-level reference model.
module tb_boot_loader;
  localparam int RH = 4;
  logic        clk = 1'b0, reset, load_start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, imem_we, cpu_reset, load_done, load_error;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  int tests = 0, fails = 0;
  bit gaps = 0;
  logic [7:0]  stream[$];
  logic [31:0] expq[$];

  boot_loader #(.DEPTH(256), .ADDR_W(8), .RESET_HOLD(RH)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (imem_we) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        chk("write", {imem_addr, imem_wdata}, e);
      end
    end
    if (imem_we || load_done || load_error) chk("ready_low", byte_ready, 0);
  end

  task automatic make(input int n, input bit good);
    logic [7:0] x;
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < 3 * n; i++) stream.push_back(8'($urandom));
    x = 0;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1;
    for (int t = 0; t < 200; t++) begin
      if (byte_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    byte_valid = 0;
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic reset_check();
    chk("reset_vals", {byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error},
        {1'b0, 1'b0, 8'h00, 24'h0, 1'b1, 1'b0, 1'b0});
  endtask

  // Start a load, feed the first n_send bytes of stream, and check the outcome if complete.
  task automatic run(input int n_send);
    int n, k;
    logic [7:0] x;
    bit good;
    n = int'(stream[0]);
    for (int i = 0; i < n; i++)
      if (3 * i + 4 <= n_send)
        expq.push_back({8'(i), stream[3*i+1], stream[3*i+2], stream[3*i+3]});
    x = 0;
    for (int i = 0; i <= 3 * n; i++) x ^= stream[i];
    good = stream[3*n+1] == x;
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("start_state", {cpu_reset, byte_ready, load_done, load_error}, 4'b1100);
    for (int i = 0; i < n_send; i++) send_byte(stream[i]);
    if (n_send != stream.size()) return;
    if (good) begin
      k = 0;
      while (cpu_reset && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("hold_cycles", k, RH);
      chk("run_state", {cpu_reset, load_done, load_error, byte_ready}, 4'b0100);
    end else begin
      chk("err_state", {cpu_reset, load_done, load_error, byte_ready}, 4'b1010);
      repeat (8) @(negedge clk);
      chk("err_stays", {cpu_reset, load_done, load_error}, 3'b101);
    end
    chk("writes_drained", expq.size(), 0);
  endtask

  task automatic case1(input bit good);
    logic [7:0] x;
    stream = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'h11, 8'h22, 8'h33};
    x = 0;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(good ? x : x ^ 8'h01);
  endtask

  initial begin
    reset = 1; load_start = 0; byte_valid = 0; byte_in = 0;
    repeat (2) @(negedge clk);
    reset_check();
    reset = 0;
    @(negedge clk);
    chk("idle_state", {cpu_reset, byte_ready, load_done, load_error}, 4'b1000);
    case1(1); run(stream.size());
    case1(0); run(stream.size());
    case1(1); run(stream.size());
    stream = '{8'h00, 8'h00}; run(2);
    stream = '{8'h00, 8'h01}; run(2);
    gaps = 1;
    case1(1); run(stream.size());
    for (int r = 0; r < 8; r++) begin
      make($urandom_range(0, 6), $urandom_range(0, 3) != 0);
      run(stream.size());
    end
    case1(1); run(5);
    reset = 1;
    @(negedge clk);
    reset_check();
    reset = 0;
    case1(1); run(stream.size());
    load_start = 1; reset = 1;
    @(negedge clk);
    load_start = 0; reset = 0;
    chk("reset_wins", {cpu_reset, byte_ready, load_done, load_error}, 4'b1000);
    @(negedge clk);
    chk("reset_wins_hold", {cpu_reset, byte_ready, load_done, load_error}, 4'b1000);
    make(3, 1); run(stream.size());
    make(2, 1); run(stream.size());
    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
